// File: rtl/dmem_port_if.sv
// Requester, result and memory-port signals of the data-memory arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dmem_port_if #(
    parameter int ADDR_W = 10
);
    logic              r0_req;
    logic              r0_we;
    logic [1:0]        r0_size;
    logic [ADDR_W-1:0] r0_addr;
    logic [63:0]       r0_wdata;
    logic              r0_ready;

    logic              r1_req;
    logic              r1_we;
    logic [1:0]        r1_size;
    logic [ADDR_W-1:0] r1_addr;
    logic [63:0]       r1_wdata;
    logic              r1_ready;

    logic [63:0]       rdata;
    logic              err;
    logic              busy;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [3:0]        m_be;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    modport slave (
        input  r0_req, r0_we, r0_size, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_size, r1_addr, r1_wdata,
        output r0_ready, r1_ready, rdata, err, busy,
        output m_en, m_we, m_addr, m_be, m_wdata,
        input  m_rdata
    );

    modport master (
        output r0_req, r0_we, r0_size, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_size, r1_addr, r1_wdata,
        input  r0_ready, r1_ready, rdata, err, busy,
        input  m_en, m_we, m_addr, m_be, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin two-requester arbiter for the big-endian 32-bit data memory port.
// Splits doubles into two word beats and assembles 64-bit read results.
module dmem_port_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_port_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RWAIT,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    state_t            state;
    state_t            state_nx;
    logic              last_grant;
    logic              gnt;
    logic              we_q;
    logic              err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [63:0]       rdata_q;

    logic              any_req;
    logic              pick;
    logic              p_we;
    logic [1:0]        p_size;
    logic [ADDR_W-1:0] p_addr;
    logic [63:0]       p_wdata;
    logic              p_bad;
    logic              is_byte;
    logic              is_dbl;
    logic [ADDR_W-1:0] word_addr;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [3:0]        m_be;
    logic [31:0]       m_wdata;

    assign any_req   = bus.r0_req | bus.r1_req;
    assign is_byte   = (size_q == 2'b00);
    assign is_dbl    = (size_q == 2'b10);
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    // Both requesting: the one not served last time wins.
    always_comb begin
        pick = bus.r1_req;
        if (bus.r0_req && bus.r1_req) begin
            pick = ~last_grant;
        end
        p_we    = pick ? bus.r1_we    : bus.r0_we;
        p_size  = pick ? bus.r1_size  : bus.r0_size;
        p_addr  = pick ? bus.r1_addr  : bus.r0_addr;
        p_wdata = pick ? bus.r1_wdata : bus.r0_wdata;
        p_bad   = (p_size == 2'b11) || (p_addr[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt        <= pick;
                        last_grant <= pick;
                        we_q       <= p_we;
                        size_q     <= p_size;
                        addr_q     <= p_addr;
                        wdata_q    <= p_wdata;
                        err_q      <= p_bad;
                        if (p_bad) begin
                            rdata_q <= '0;
                        end
                    end
                end
                BEAT1: begin
                    if (!we_q) begin
                        rdata_q[31:0] <= bus.m_rdata;
                    end
                end
                RWAIT: begin
                    unique case (1'b1)
                        is_byte: rdata_q <= {56'b0, bus.m_rdata[7:0]};
                        is_dbl:  rdata_q[63:32] <= bus.m_rdata;
                        default: rdata_q <= {32'b0, bus.m_rdata};
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        m_en     = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_be     = 4'b0000;
        m_wdata  = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = p_bad ? DONE : BEAT0;
                end
            end
            BEAT0: begin
                m_en   = 1'b1;
                m_we   = we_q;
                m_addr = word_addr;
                if (is_byte) begin
                    m_be    = 4'b0001;
                    m_wdata = {24'b0, wdata_q[7:0]};
                end else begin
                    m_be    = 4'b1111;
                    m_wdata = wdata_q[31:0];
                end
                if (is_dbl) begin
                    state_nx = BEAT1;
                end else begin
                    state_nx = we_q ? DONE : RWAIT;
                end
            end
            BEAT1: begin
                m_en     = 1'b1;
                m_we     = we_q;
                m_addr   = word_addr + STEP;
                m_be     = 4'b1111;
                m_wdata  = wdata_q[63:32];
                state_nx = we_q ? DONE : RWAIT;
            end
            RWAIT:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.m_en     = m_en;
    assign bus.m_we     = m_we;
    assign bus.m_addr   = m_addr;
    assign bus.m_be     = m_be;
    assign bus.m_wdata  = m_wdata;
    assign bus.r0_ready = (state == DONE) && !gnt;
    assign bus.r1_ready = (state == DONE) && gnt;
    assign bus.err      = (state == DONE) && err_q;
    assign bus.busy     = (state != IDLE);
    assign bus.rdata    = rdata_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter against a transaction-level model
// of arbitration order, latency, memory beats and returned data.
module tb_dmem_port_arbiter;
    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_port_if #(.ADDR_W(AW)) bus ();

    dmem_port_arbiter #(.ADDR_W(AW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [9:0]  addr;
        logic [63:0] wdata;
        logic        has_lit;
        logic [63:0] lit;
    } txn_t;

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    int checks = 0;
    int errors = 0;

    txn_t  q0[$];
    txn_t  q1[$];
    beat_t beats[$];
    int    order[$];

    logic [7:0]  mem     [DEPTH];
    logic [7:0]  ref_mem [DEPTH];
    logic        last_m;
    logic [63:0] rdata_m;

    function automatic logic [7:0] init_byte(int i);
        return 8'((i * 37 + 5) ^ (i >> 3));
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory behind the port: big-endian, be[3] is the lowest byte address.
    initial begin
        bus.m_rdata <= '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (bus.m_en) begin
                if (bus.m_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.m_be[b]) begin
                            mem[int'(bus.m_addr) + 3 - b] = bus.m_wdata[8*b +: 8];
                        end
                    end
                end else begin
                    bus.m_rdata <= {mem[int'(bus.m_addr)],
                                    mem[int'(bus.m_addr) + 1],
                                    mem[int'(bus.m_addr) + 2],
                                    mem[int'(bus.m_addr) + 3]};
                end
            end
        end
    end

    // Per-cycle bus rules plus a log of every memory beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.m_en) begin
                beats.push_back('{bus.m_we, bus.m_addr, bus.m_be, bus.m_wdata});
                chk("beat_align", {62'b0, bus.m_addr[1:0]}, 64'd0);
            end else begin
                chk("idle_m_we", {63'b0, bus.m_we}, 64'd0);
            end
            chk("ready_excl", {63'b0, bus.r0_ready & bus.r1_ready}, 64'd0);
            if (bus.err) chk("err_ready", {63'b0, bus.r0_ready | bus.r1_ready}, 64'd1);
        end
    end

    function automatic logic [31:0] rd_word(int a);
        return {ref_mem[a], ref_mem[a + 1], ref_mem[a + 2], ref_mem[a + 3]};
    endfunction

    function automatic void wr_word(int a, logic [31:0] w);
        ref_mem[a]     = w[31:24];
        ref_mem[a + 1] = w[23:16];
        ref_mem[a + 2] = w[15:8];
        ref_mem[a + 3] = w[7:0];
    endfunction

    function automatic logic is_bad(txn_t t);
        return (t.size == 2'b11) || (t.addr[1:0] != 2'b00);
    endfunction

    function automatic int lat(txn_t t);
        if (is_bad(t)) return 1;
        if (t.size == 2'b10) return t.we ? 3 : 4;
        return t.we ? 2 : 3;
    endfunction

    function automatic int nbeats(txn_t t);
        if (is_bad(t)) return 0;
        return (t.size == 2'b10) ? 2 : 1;
    endfunction

    function automatic beat_t exp_beat(txn_t t, int i);
        beat_t e;
        int a;
        a = int'(t.addr);
        e.we = t.we;
        if (i == 0) begin
            e.addr  = t.addr;
            e.be    = (t.size == 2'b00) ? 4'b0001 : 4'b1111;
            e.wdata = (t.size == 2'b00) ? {24'b0, t.wdata[7:0]} : t.wdata[31:0];
        end else begin
            e.addr  = 10'((a + 4) % DEPTH);
            e.be    = 4'b1111;
            e.wdata = t.wdata[63:32];
        end
        return e;
    endfunction

    // Applies one access to the reference memory; returns the expected rdata.
    function automatic logic [63:0] model_apply(txn_t t);
        int a, a4;
        a  = int'(t.addr);
        a4 = (a + 4) % DEPTH;
        if (is_bad(t)) begin
            rdata_m = '0;
        end else if (t.we) begin
            case (t.size)
                2'b00:   ref_mem[a + 3] = t.wdata[7:0];
                2'b01:   wr_word(a, t.wdata[31:0]);
                default: begin
                    wr_word(a, t.wdata[31:0]);
                    wr_word(a4, t.wdata[63:32]);
                end
            endcase
        end else begin
            case (t.size)
                2'b00:   rdata_m = {56'b0, ref_mem[a + 3]};
                2'b01:   rdata_m = {32'b0, rd_word(a)};
                default: rdata_m = {rd_word(a4), rd_word(a)};
            endcase
        end
        return rdata_m;
    endfunction

    function automatic txn_t mk(logic we, logic [1:0] size, logic [9:0] addr,
                                logic [63:0] wdata, logic has_lit,
                                logic [63:0] lit);
        txn_t t;
        t.we = we; t.size = size; t.addr = addr; t.wdata = wdata;
        t.has_lit = has_lit; t.lit = lit;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        txn_t t;
        t.we      = 1'($urandom_range(0, 1));
        t.size    = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        t.addr    = ($urandom_range(0, 7) == 0) ? 10'($urandom) : {8'($urandom), 2'b00};
        t.wdata   = {$urandom, $urandom};
        t.has_lit = 1'b0;
        t.lit     = '0;
        return t;
    endfunction

    task automatic drive_heads();
        if (q0.size() != 0) begin
            bus.r0_req = 1'b1;   bus.r0_we = q0[0].we; bus.r0_size = q0[0].size;
            bus.r0_addr = q0[0].addr; bus.r0_wdata = q0[0].wdata;
        end else begin
            bus.r0_req = 1'b0;
        end
        if (q1.size() != 0) begin
            bus.r1_req = 1'b1;   bus.r1_we = q1[0].we; bus.r1_size = q1[0].size;
            bus.r1_addr = q1[0].addr; bus.r1_wdata = q1[0].wdata;
        end else begin
            bus.r1_req = 1'b0;
        end
    endtask

    // Entered #1 after an edge with the DUT idle and queue heads presented.
    task automatic serve();
        txn_t        t;
        int          k, n;
        logic        win;
        logic [63:0] ex;
        beat_t       eb;
        while (q0.size() != 0 || q1.size() != 0) begin
            if (q0.size() != 0 && q1.size() != 0) win = ~last_m;
            else win = (q1.size() != 0);
            last_m = win;
            order.push_back(int'(win));
            t  = win ? q1[0] : q0[0];
            k  = lat(t);
            n  = nbeats(t);
            ex = model_apply(t);
            beats.delete();
            for (int c = 1; c <= k; c++) begin
                @(posedge clk); #1;
                chk("busy", {63'b0, bus.busy}, 64'd1);
                if (c < k) begin
                    chk("early_ready", {62'b0, bus.r1_ready, bus.r0_ready}, 64'd0);
                end else begin
                    chk("ready", {62'b0, bus.r1_ready, bus.r0_ready},
                        win ? 64'd2 : 64'd1);
                    chk("err", {63'b0, bus.err}, {63'b0, is_bad(t)});
                    chk("rdata", bus.rdata, ex);
                    if (t.has_lit) chk("lit_rdata", bus.rdata, t.lit);
                end
            end
            if (win) void'(q1.pop_front());
            else void'(q0.pop_front());
            drive_heads();
            @(posedge clk); #1;
            chk("gap_busy", {63'b0, bus.busy}, 64'd0);
            chk("gap_ready", {62'b0, bus.r1_ready, bus.r0_ready}, 64'd0);
            chk("beat_count", 64'(beats.size()), 64'(n));
            for (int i = 0; i < n && i < beats.size(); i++) begin
                eb = exp_beat(t, i);
                chk("beat_we", {63'b0, beats[i].we}, {63'b0, eb.we});
                chk("beat_addr", {54'b0, beats[i].addr}, {54'b0, eb.addr});
                chk("beat_be", {60'b0, beats[i].be}, {60'b0, eb.be});
                if (eb.we) chk("beat_wdata", {32'b0, beats[i].wdata}, {32'b0, eb.wdata});
            end
        end
    endtask

    task automatic chk_order(input string name, input int a, input int b, input int c);
        chk({name, "_len"}, 64'(order.size()), (c < 0) ? 64'd2 : 64'd3);
        if (order.size() >= 2) begin
            chk({name, "_0"}, 64'(order[0]), 64'(a));
            chk({name, "_1"}, 64'(order[1]), 64'(b));
        end
        if (c >= 0 && order.size() >= 3) chk({name, "_2"}, 64'(order[2]), 64'(c));
        order.delete();
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog no progress");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_byte(i);
        last_m  = 1'b1;
        rdata_m = '0;
        bus.r0_req = 0; bus.r0_we = 0; bus.r0_size = 0; bus.r0_addr = 0; bus.r0_wdata = 0;
        bus.r1_req = 0; bus.r1_we = 0; bus.r1_size = 0; bus.r1_addr = 0; bus.r1_wdata = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", bus.rdata, 64'd0);
        chk("rst_ready", {62'b0, bus.r1_ready, bus.r0_ready}, 64'd0);
        chk("rst_err_busy", {62'b0, bus.err, bus.busy}, 64'd0);
        chk("rst_m_ctl", {62'b0, bus.m_en, bus.m_we}, 64'd0);
        chk("rst_m_be", {60'b0, bus.m_be}, 64'd0);
        chk("rst_m_addr", {54'b0, bus.m_addr}, 64'd0);
        chk("rst_m_wdata", {32'b0, bus.m_wdata}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Both from reset: r0, then r1 ahead of r0's immediate re-request.
        q0.push_back(mk(1, 2'b01, 10'h100, 64'h0000_0000_1234_5678, 0, 0));
        q0.push_back(mk(0, 2'b01, 10'h100, 64'h0, 1, 64'h0000_0000_1234_5678));
        q1.push_back(mk(1, 2'b01, 10'h200, 64'h0000_0000_ABCD_EF01, 0, 0));
        drive_heads();
        serve();
        chk_order("order_pair", 0, 1, 0);

        q0.push_back(mk(1, 2'b01, 10'h010, 64'h0000_0000_DEAD_BEEF, 0, 0));
        q0.push_back(mk(0, 2'b01, 10'h010, 64'h0, 1, 64'h0000_0000_DEAD_BEEF));
        q1.push_back(mk(1, 2'b10, 10'h3FC, 64'h1122_3344_5566_7788, 0, 0));
        q1.push_back(mk(0, 2'b10, 10'h3FC, 64'h0, 1, 64'h1122_3344_5566_7788));
        q0.push_back(mk(1, 2'b01, 10'h020, 64'h0000_0000_0000_0020, 0, 0));
        q0.push_back(mk(1, 2'b00, 10'h020, 64'h0000_0000_0000_00A5, 0, 0));
        q0.push_back(mk(0, 2'b01, 10'h020, 64'h0, 1, 64'h0000_0000_0000_00A5));
        q0.push_back(mk(0, 2'b00, 10'h020, 64'h0, 1, 64'h0000_0000_0000_00A5));
        q0.push_back(mk(0, 2'b01, 10'h013, 64'h0, 1, 64'h0));
        q1.push_back(mk(0, 2'b11, 10'h000, 64'h0, 1, 64'h0));
        drive_heads();
        serve();
        order.delete();

        for (int r = 0; r < 60; r++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                chk("rand_idle_busy", {63'b0, bus.busy}, 64'd0);
            end
            repeat ($urandom_range(0, 3)) q0.push_back(rnd_txn());
            repeat ($urandom_range(0, 3)) q1.push_back(rnd_txn());
            if (q0.size() == 0 && q1.size() == 0) q0.push_back(rnd_txn());
            drive_heads();
            serve();
        end
        order.delete();

        // Reset in BEAT1 of a double write: only beat 0 reaches memory.
        q0.push_back(mk(1, 2'b10, 10'h080, 64'hCAFE_BABE_0BAD_F00D, 0, 0));
        drive_heads();
        q0.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_beat1", {53'b0, bus.m_en, bus.m_addr}, {53'b0, 1'b1, 10'h084});
        rst_n = 1'b0;
        #1;
        chk("rst_mid_m_en", {63'b0, bus.m_en}, 64'd0);
        chk("rst_mid_ready", {62'b0, bus.r1_ready, bus.r0_ready}, 64'd0);
        chk("rst_mid_busy", {63'b0, bus.busy}, 64'd0);
        bus.r0_req = 1'b0;
        wr_word(32'h080, 32'h0BAD_F00D);
        last_m  = 1'b1;
        rdata_m = '0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_busy", {63'b0, bus.busy}, 64'd0);
            chk("post_rst_ready", {62'b0, bus.r1_ready, bus.r0_ready}, 64'd0);
        end
        q1.push_back(mk(0, 2'b01, 10'h084, 64'h0, 0, 0));
        q0.push_back(mk(0, 2'b01, 10'h080, 64'h0, 1, 64'h0000_0000_0BAD_F00D));
        drive_heads();
        serve();
        chk_order("order_post_rst", 0, 1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
